// File: rtl/afg_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : afg_mux_pkg
// Purpose  : Shared state encoding, select-width helper and reset constants
//            for the AFG N-channel mode mux.
// Revision : 1.0 - initial release
// ============================================================================
package afg_mux_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle = 2'd0;
  localparam state_t c_st_run  = 2'd1;
  localparam state_t c_st_pend = 2'd2;

  localparam logic c_rst_valid = 1'b0;
  localparam logic c_rst_done  = 1'b0;

  function automatic int sel_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/afg_mode_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : afg_mode_mux_if
// Purpose  : Control, sample-stream and output bundle of the AFG mode mux.
// Revision : 1.0 - initial release
// ============================================================================
interface afg_mode_mux_if #(
  parameter int WIDTH  = 12,
  parameter int NCH    = 4,
  parameter int BCNT_W = 16
);
  import afg_mux_pkg::*;

  localparam int SELW = sel_width(NCH);

  logic                 en;
  logic                 start;
  logic                 mode;
  logic [BCNT_W-1:0]    burst_len;
  logic [SELW-1:0]      sel;
  logic                 sel_load;
  logic [NCH*WIDTH-1:0] din;
  logic                 din_valid;
  logic [NCH-1:0]       din_wrap;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic [SELW-1:0]      active_sel;
  logic                 busy;
  logic                 done;

  modport master (
    output en, start, mode, burst_len, sel, sel_load, din, din_valid, din_wrap,
    input  dout, dout_valid, active_sel, busy, done
  );

  modport slave (
    input  en, start, mode, burst_len, sel, sel_load, din, din_valid, din_wrap,
    output dout, dout_valid, active_sel, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/afg_burst_counter.sv
`default_nettype none
// ============================================================================
// Module   : afg_burst_counter
// Purpose  : Burst period counter; loads length and clears at start, counts
//            qualified wraps, flags the wrap that completes the burst.
// Revision : 1.0 - initial release
// ============================================================================
module afg_burst_counter #(
  parameter int BCNT_W = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_load,
  input  wire logic [BCNT_W-1:0] i_len,
  input  wire logic              i_inc,
  output logic                   o_terminal
);

  logic [BCNT_W-1:0] r_count;
  logic [BCNT_W-1:0] r_len;
  logic [BCNT_W-1:0] w_count_nxt;

  assign w_count_nxt = r_count + {{(BCNT_W-1){1'b0}}, 1'b1};

  // A zero length never terminates, giving infinite behaviour.
  assign o_terminal = i_inc && (r_len != '0) && (w_count_nxt == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_len   <= '0;
    end else if (i_load) begin
      r_count <= '0;
      r_len   <= i_len;
    end else if (i_inc) begin
      r_count <= w_count_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/afg_mode_mux.sv
`default_nettype none
// ============================================================================
// Module   : afg_mode_mux
// Purpose  : N-channel AFG sample selector; channel switches commit only at
//            the active channel's period boundary. Burst mode is compiled in
//            with AFG_MUX_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module afg_mode_mux
  import afg_mux_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int NCH    = 4,
  parameter int BCNT_W = 16
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  afg_mode_mux_if.slave bus
);

  localparam int SELW = sel_width(NCH);

  state_t           r_state;
  logic [SELW-1:0]  r_active_sel;
  logic [SELW-1:0]  r_pend_sel;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_done;

  logic [WIDTH-1:0] w_sample;
  logic             w_wrap;
  logic             w_sel_ok;
  logic             w_sel_req;
  logic             w_cancel;
  logic             w_start_go;
  logic             w_terminal;
  logic [SELW-1:0]  w_start_sel;
  logic [SELW-1:0]  w_pend_nxt;

  assign w_sample    = bus.din[32'(r_active_sel) * WIDTH +: WIDTH];
  assign w_wrap      = bus.din_valid && bus.din_wrap[r_active_sel];
  assign w_sel_ok    = 32'(bus.sel) < NCH;
  assign w_sel_req   = bus.sel_load && w_sel_ok;
  assign w_cancel    = bus.sel_load && (bus.sel == r_active_sel);
  assign w_start_go  = bus.en && bus.start && (r_state == c_st_idle);
  assign w_start_sel = w_sel_ok ? bus.sel : '0;
  // A request landing on the wrap cycle overrides the older pending one.
  assign w_pend_nxt  = w_sel_req ? bus.sel : r_pend_sel;

`ifdef AFG_MUX_BURST_EN
  logic r_mode;
  logic w_count_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
    end else if (w_start_go) begin
      r_mode <= bus.mode;
    end
  end

  assign w_count_inc = bus.en && r_mode && w_wrap && (r_state != c_st_idle);

  afg_burst_counter #(
    .BCNT_W(BCNT_W)
  ) u_burst_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_start_go),
    .i_len     (bus.burst_len),
    .i_inc     (w_count_inc),
    .o_terminal(w_terminal)
  );
`else
  logic              w_unused_mode;
  logic [BCNT_W-1:0] w_unused_len;

  assign w_unused_mode = bus.mode;
  assign w_unused_len  = bus.burst_len;
  assign w_terminal    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_active_sel <= '0;
      r_pend_sel   <= '0;
      r_dout       <= '0;
      r_dout_valid <= c_rst_valid;
      r_done       <= c_rst_done;
    end else if (!bus.en) begin
      r_state      <= c_st_idle;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == c_st_idle) begin
        r_dout       <= '0;
        r_dout_valid <= 1'b0;
        if (w_start_go) begin
          r_state      <= c_st_run;
          r_active_sel <= w_start_sel;
        end
      end else begin
        r_dout_valid <= bus.din_valid;
        if (bus.din_valid) begin
          r_dout <= w_sample;
        end
        // Burst completion discards any pending switch.
        if (w_terminal) begin
          r_state <= c_st_idle;
          r_done  <= 1'b1;
        end else if (r_state == c_st_pend) begin
          if (w_cancel) begin
            r_state <= c_st_run;
          end else if (w_wrap) begin
            r_active_sel <= w_pend_nxt;
            r_state      <= c_st_run;
          end else if (w_sel_req) begin
            r_pend_sel <= bus.sel;
          end
        end else if (r_state == c_st_run) begin
          if (w_sel_req && !w_cancel) begin
            r_pend_sel <= bus.sel;
            r_state    <= c_st_pend;
          end
        end else begin
          r_state <= c_st_idle;
        end
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.active_sel = r_active_sel;
  assign bus.busy       = (r_state != c_st_idle);
  assign bus.done       = r_done;

endmodule
`default_nettype wire
